hazard_control_unit: RTL and testbench

- Pipeline sequencer that sits beside the forwarding_unit in the 5-stage datapath.
- Owns the pipeline-register write enables and flushes: IF/ID, ID/EX and EX/MEM.
- Resolves the hazards that forwarding cannot cover: load-use, multi-cycle MUL/DIV occupancy of EX, taken branches and program halt.
- Keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_control_unit_pkg.sv | 18 +
 rtl/hazard_control_unit_if.sv | 38 +++
 rtl/hazard_control_unit_hazard_detect.sv | 21 ++
 rtl/hazard_control_unit.sv | 138 +++++++++++++
 tb/tb_hazard_control_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_control_unit_pkg.sv
// rtl/hazard_control_unit_pkg.sv - shared state encodings and default widths for the hazard and forwarding units
package hazard_control_unit_pkg;

    localparam int HCU_REG_W         = 4;
    localparam int HCU_MULDIV_CYCLES = 4;
    localparam int HCU_CNT_W         = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MULDIV = 2'd1,
        ST_HALT   = 2'd2
    } hcu_state_t;

    function automatic logic reg_match(input logic [HCU_REG_W-1:0] a, input logic [HCU_REG_W-1:0] b);
        return a == b;
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - datapath <-> hazard control unit signal bundle
interface hazard_control_unit_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] registerOP1ID;
    logic [REG_W-1:0] registerOP2ID;
    logic             useOP2ID;
    logic [REG_W-1:0] registerOP1EX;
    logic             memReadEX;
    logic             mulStartEX;
    logic             branchTakenEX;
    logic             haltID;

    logic             pcWrite;
    logic             ifIdWrite;
    logic             idExWrite;
    logic             ifIdFlush;
    logic             idExFlush;
    logic             exMemBubble;
    logic             halted;
    logic [CNT_W-1:0] stallCycles;

    // master: the datapath side; slave: the hazard control unit
    modport master (
        output registerOP1ID, registerOP2ID, useOP2ID, registerOP1EX,
               memReadEX, mulStartEX, branchTakenEX, haltID,
        input  pcWrite, ifIdWrite, idExWrite, ifIdFlush, idExFlush,
               exMemBubble, halted, stallCycles
    );

    modport slave (
        input  registerOP1ID, registerOP2ID, useOP2ID, registerOP1EX,
               memReadEX, mulStartEX, branchTakenEX, haltID,
        output pcWrite, ifIdWrite, idExWrite, ifIdFlush, idExFlush,
               exMemBubble, halted, stallCycles
    );
endinterface

// File: rtl/hazard_control_unit_hazard_detect.sv
// rtl/hazard_control_unit_hazard_detect.sv - combinational load-use comparator
module hazard_detect
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_W = HCU_REG_W
) (
    input  logic [REG_W-1:0] i_registerOP1ID,
    input  logic [REG_W-1:0] i_registerOP2ID,
    input  logic             i_useOP2ID,
    input  logic [REG_W-1:0] i_registerOP1EX,
    input  logic             i_memReadEX,
    output logic             o_loadUse
);
    logic w_op1Hit;
    logic w_op2Hit;

    // Register 0 is compared like any other register.
    assign w_op1Hit  = (i_registerOP1EX == i_registerOP1ID);
    assign w_op2Hit  = i_useOP2ID && (i_registerOP1EX == i_registerOP2ID);
    assign o_loadUse = i_memReadEX && (w_op1Hit || w_op2Hit);
endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush sequencer with MUL/DIV freeze, halt and stall counter
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_W         = HCU_REG_W,
    parameter int MULDIV_CYCLES = HCU_MULDIV_CYCLES,
    parameter int CNT_W         = HCU_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_control_unit_if.slave bus
);
    localparam int BUSY_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;

    hcu_state_t        r_state;
    hcu_state_t        w_nextState;
    logic [BUSY_W-1:0] r_busyCnt;
    logic [BUSY_W-1:0] w_nextBusyCnt;
    logic [CNT_W-1:0]  r_stallCycles;

    logic w_loadUse;
    logic w_pcWrite;
    logic w_ifIdWrite;
    logic w_idExWrite;
    logic w_ifIdFlush;
    logic w_idExFlush;
    logic w_exMemBubble;
    logic w_halted;
    logic w_countStall;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .i_registerOP1ID (bus.registerOP1ID),
        .i_registerOP2ID (bus.registerOP2ID),
        .i_useOP2ID      (bus.useOP2ID),
        .i_registerOP1EX (bus.registerOP1EX),
        .i_memReadEX     (bus.memReadEX),
        .o_loadUse       (w_loadUse)
    );

    always_comb begin
        w_nextState   = r_state;
        w_nextBusyCnt = r_busyCnt;
        w_pcWrite     = 1'b1;
        w_ifIdWrite   = 1'b1;
        w_idExWrite   = 1'b1;
        w_ifIdFlush   = 1'b0;
        w_idExFlush   = 1'b0;
        w_exMemBubble = 1'b0;
        w_halted      = 1'b0;

        unique case (r_state)
            ST_RUN: begin
                // A taken branch squashes the ID instruction, so its MUL/halt/load-use state is moot.
                if (bus.branchTakenEX) begin
                    w_ifIdFlush = 1'b1;
                    w_idExFlush = 1'b1;
                end else if (bus.mulStartEX) begin
                    w_nextState   = ST_MULDIV;
                    w_nextBusyCnt = BUSY_W'(MULDIV_CYCLES - 1);
                    w_pcWrite     = 1'b0;
                    w_ifIdWrite   = 1'b0;
                    w_idExWrite   = 1'b0;
                    w_exMemBubble = 1'b1;
                end else if (w_loadUse) begin
                    w_pcWrite   = 1'b0;
                    w_ifIdWrite = 1'b0;
                    w_idExFlush = 1'b1;
                end else if (bus.haltID) begin
                    w_nextState = ST_HALT;
                    w_pcWrite   = 1'b0;
                    w_idExFlush = 1'b1;
                end
            end
            ST_MULDIV: begin
                w_pcWrite     = 1'b0;
                w_ifIdWrite   = 1'b0;
                w_idExWrite   = 1'b0;
                w_exMemBubble = 1'b1;
                if (r_busyCnt <= BUSY_W'(1)) begin
                    w_nextState   = ST_RUN;
                    w_nextBusyCnt = '0;
                end else begin
                    w_nextBusyCnt = r_busyCnt - BUSY_W'(1);
                end
            end
            ST_HALT: begin
                // ID/EX keeps loading so bubbles drain the back end.
                w_pcWrite   = 1'b0;
                w_ifIdWrite = 1'b0;
                w_idExFlush = 1'b1;
                w_halted    = 1'b1;
            end
            default: begin
                w_nextState   = ST_RUN;
                w_nextBusyCnt = '0;
            end
        endcase

        if (reset) begin
            w_nextState   = ST_RUN;
            w_nextBusyCnt = '0;
            w_pcWrite     = 1'b0;
            w_ifIdWrite   = 1'b0;
            w_idExWrite   = 1'b0;
            w_ifIdFlush   = 1'b1;
            w_idExFlush   = 1'b1;
            w_exMemBubble = 1'b1;
            w_halted      = 1'b0;
        end
    end

    assign w_countStall = !w_pcWrite && (r_state != ST_HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_busyCnt     <= '0;
            r_stallCycles <= '0;
        end else begin
            r_state   <= w_nextState;
            r_busyCnt <= w_nextBusyCnt;
            if (w_countStall && (r_stallCycles != {CNT_W{1'b1}})) begin
                r_stallCycles <= r_stallCycles + CNT_W'(1);
            end
        end
    end

    assign bus.pcWrite     = w_pcWrite;
    assign bus.ifIdWrite   = w_ifIdWrite;
    assign bus.idExWrite   = w_idExWrite;
    assign bus.ifIdFlush   = w_ifIdFlush;
    assign bus.idExFlush   = w_idExFlush;
    assign bus.exMemBubble = w_exMemBubble;
    assign bus.halted      = w_halted;
    assign bus.stallCycles = r_stallCycles;
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    hazard_control_unit_if #(.REG_W(4), .CNT_W(16)) bus ();
    hazard_control_unit_if #(.REG_W(4), .CNT_W(4))  bus_s ();

    hazard_control_unit #(.REG_W(4), .MULDIV_CYCLES(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Narrow counter instance so saturation is reachable in a few cycles.
    hazard_control_unit #(.REG_W(4), .MULDIV_CYCLES(4), .CNT_W(4)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.registerOP1ID = 4'd0;
        bus.registerOP2ID = 4'd0;
        bus.useOP2ID      = 1'b0;
        bus.registerOP1EX = 4'd15;
        bus.memReadEX     = 1'b0;
        bus.mulStartEX    = 1'b0;
        bus.branchTakenEX = 1'b0;
        bus.haltID        = 1'b0;
    endtask

    task automatic idle_s();
        bus_s.registerOP1ID = 4'd0;
        bus_s.registerOP2ID = 4'd0;
        bus_s.useOP2ID      = 1'b0;
        bus_s.registerOP1EX = 4'd15;
        bus_s.memReadEX     = 1'b0;
        bus_s.mulStartEX    = 1'b0;
        bus_s.branchTakenEX = 1'b0;
        bus_s.haltID        = 1'b0;
    endtask

    // Advance past the next rising edge; inputs are then changed at edge+1, sampled at edge+3.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        idle_s();
        tick();
        tick();
        #2;
        checks++; if (bus.pcWrite !== 1'b0 || bus.ifIdWrite !== 1'b0 || bus.idExWrite !== 1'b0) begin
            failures++; $display("FAIL rst_enables got=%b%b%b exp=000", bus.pcWrite, bus.ifIdWrite, bus.idExWrite); end
        checks++; if (bus.ifIdFlush !== 1'b1 || bus.idExFlush !== 1'b1 || bus.exMemBubble !== 1'b1 || bus.halted !== 1'b0) begin
            failures++; $display("FAIL rst_flush got=%b%b%b halted=%b exp=111 halted=0", bus.ifIdFlush, bus.idExFlush, bus.exMemBubble, bus.halted); end
        reset = 1'b0;
        tick();
        #2;
        checks++; if (bus.pcWrite !== 1'b1 || bus.ifIdWrite !== 1'b1 || bus.idExWrite !== 1'b1) begin
            failures++; $display("FAIL idle_enables got=%b%b%b exp=111", bus.pcWrite, bus.ifIdWrite, bus.idExWrite); end
        checks++; if (bus.ifIdFlush !== 1'b0 || bus.idExFlush !== 1'b0 || bus.exMemBubble !== 1'b0 || bus.halted !== 1'b0) begin
            failures++; $display("FAIL idle_flush got=%b%b%b halted=%b exp=000 halted=0", bus.ifIdFlush, bus.idExFlush, bus.exMemBubble, bus.halted); end
        checks++; if (bus.stallCycles !== 16'd0) begin
            failures++; $display("FAIL idle_cnt got=%0d exp=0", bus.stallCycles); end
    endtask

    task automatic test_load_use();
        bus.memReadEX     = 1'b1;
        bus.registerOP1EX = 4'b0101;
        bus.registerOP2ID = 4'b0101;
        bus.registerOP1ID = 4'b0011;
        bus.useOP2ID      = 1'b1;
        #2;
        checks++; if (bus.pcWrite !== 1'b0 || bus.ifIdWrite !== 1'b0 || bus.idExFlush !== 1'b1 || bus.idExWrite !== 1'b1) begin
            failures++; $display("FAIL lu_op2 pc=%b ifid=%b idexfl=%b idexwr=%b exp=0 0 1 1", bus.pcWrite, bus.ifIdWrite, bus.idExFlush, bus.idExWrite); end
        checks++; if (bus.ifIdFlush !== 1'b0 || bus.exMemBubble !== 1'b0) begin
            failures++; $display("FAIL lu_op2_other ifidfl=%b bubble=%b exp=0 0", bus.ifIdFlush, bus.exMemBubble); end
        tick();
        idle();
        #2;
        checks++; if (bus.pcWrite !== 1'b1 || bus.idExFlush !== 1'b0) begin
            failures++; $display("FAIL lu_release pc=%b idexfl=%b exp=1 0", bus.pcWrite, bus.idExFlush); end
        checks++; if (bus.stallCycles !== 16'd1) begin
            failures++; $display("FAIL lu_cnt1 got=%0d exp=1", bus.stallCycles); end
        // Same registers but OP2 unused: no hazard.
        bus.memReadEX     = 1'b1;
        bus.registerOP1EX = 4'b0101;
        bus.registerOP2ID = 4'b0101;
        bus.registerOP1ID = 4'b0011;
        bus.useOP2ID      = 1'b0;
        #2;
        checks++; if (bus.pcWrite !== 1'b1 || bus.idExFlush !== 1'b0) begin
            failures++; $display("FAIL lu_nouse pc=%b idexfl=%b exp=1 0", bus.pcWrite, bus.idExFlush); end
        tick();
        // OP1 match stalls regardless of useOP2ID.
        bus.registerOP1ID = 4'b0101;
        bus.registerOP2ID = 4'b0000;
        #2;
        checks++; if (bus.pcWrite !== 1'b0 || bus.ifIdWrite !== 1'b0) begin
            failures++; $display("FAIL lu_op1 pc=%b ifid=%b exp=0 0", bus.pcWrite, bus.ifIdWrite); end
        tick();
        // Match without a load is not a hazard (register 0 included).
        idle();
        bus.registerOP1EX = 4'd0;
        bus.registerOP1ID = 4'd0;
        #2;
        checks++; if (bus.pcWrite !== 1'b1) begin
            failures++; $display("FAIL lu_noload pc=%b exp=1", bus.pcWrite); end
        checks++; if (bus.stallCycles !== 16'd2) begin
            failures++; $display("FAIL lu_cnt2 got=%0d exp=2", bus.stallCycles); end
        tick();
        idle();
    endtask

    task automatic test_muldiv();
        int freeze;
        freeze = 0;
        bus.mulStartEX = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (bus.pcWrite === 1'b0 && bus.exMemBubble === 1'b1 && bus.idExWrite === 1'b0) freeze++;
            if (i == 2) begin
                checks++; if (bus.ifIdFlush !== 1'b0 || bus.pcWrite !== 1'b0) begin
                    failures++; $display("FAIL md_branch_ignored ifidfl=%b pc=%b exp=0 0", bus.ifIdFlush, bus.pcWrite); end
            end
            tick();
            idle();
            if (i == 1) bus.branchTakenEX = 1'b1;
        end
        checks++; if (freeze != 4) begin
            failures++; $display("FAIL md_freeze got=%0d exp=4", freeze); end
        #2;
        checks++; if (bus.pcWrite !== 1'b1 || bus.exMemBubble !== 1'b0) begin
            failures++; $display("FAIL md_resume pc=%b bubble=%b exp=1 0", bus.pcWrite, bus.exMemBubble); end
        checks++; if (bus.stallCycles !== 16'd6) begin
            failures++; $display("FAIL md_cnt got=%0d exp=6", bus.stallCycles); end
    endtask

    task automatic test_branch_priority();
        bus.branchTakenEX = 1'b1;
        bus.mulStartEX    = 1'b1;
        bus.memReadEX     = 1'b1;
        bus.registerOP1EX = 4'd7;
        bus.registerOP1ID = 4'd7;
        bus.haltID        = 1'b1;
        #2;
        checks++; if (bus.ifIdFlush !== 1'b1 || bus.idExFlush !== 1'b1 || bus.pcWrite !== 1'b1 || bus.exMemBubble !== 1'b0) begin
            failures++; $display("FAIL br_prio ifidfl=%b idexfl=%b pc=%b bubble=%b exp=1 1 1 0", bus.ifIdFlush, bus.idExFlush, bus.pcWrite, bus.exMemBubble); end
        tick();
        idle();
        #2;
        checks++; if (bus.halted !== 1'b0 || bus.pcWrite !== 1'b1 || bus.stallCycles !== 16'd6) begin
            failures++; $display("FAIL br_after halted=%b pc=%b cnt=%0d exp=0 1 6", bus.halted, bus.pcWrite, bus.stallCycles); end
    endtask

    task automatic test_halt();
        int held;
        held = 0;
        bus.haltID = 1'b1;
        #2;
        checks++; if (bus.pcWrite !== 1'b0 || bus.idExFlush !== 1'b1 || bus.halted !== 1'b0) begin
            failures++; $display("FAIL halt_entry pc=%b idexfl=%b halted=%b exp=0 1 0", bus.pcWrite, bus.idExFlush, bus.halted); end
        tick();
        idle();
        for (int i = 0; i < 10; i++) begin
            #2;
            if (bus.halted === 1'b1 && bus.pcWrite === 1'b0 && bus.ifIdWrite === 1'b0 &&
                bus.idExWrite === 1'b1 && bus.idExFlush === 1'b1) held++;
            tick();
        end
        checks++; if (held != 10) begin
            failures++; $display("FAIL halt_hold got=%0d exp=10", held); end
        #2;
        checks++; if (bus.stallCycles !== 16'd7) begin
            failures++; $display("FAIL halt_cnt got=%0d exp=7", bus.stallCycles); end
        reset = 1'b1;
        #1;
        checks++; if (bus.halted !== 1'b0) begin
            failures++; $display("FAIL halt_rst_comb halted=%b exp=0", bus.halted); end
        tick();
        reset = 1'b0;
        #2;
        checks++; if (bus.halted !== 1'b0 || bus.pcWrite !== 1'b1 || bus.stallCycles !== 16'd0) begin
            failures++; $display("FAIL halt_rst halted=%b pc=%b cnt=%0d exp=0 1 0", bus.halted, bus.pcWrite, bus.stallCycles); end
        tick();
    endtask

    task automatic test_reset_mid_muldiv();
        int freeze;
        freeze = 0;
        bus.mulStartEX = 1'b1;
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        checks++; if (bus.pcWrite !== 1'b1 || bus.exMemBubble !== 1'b0 || bus.stallCycles !== 16'd0) begin
            failures++; $display("FAIL mdrst_run pc=%b bubble=%b cnt=%0d exp=1 0 0", bus.pcWrite, bus.exMemBubble, bus.stallCycles); end
        bus.mulStartEX = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #2;
            if (bus.pcWrite === 1'b0 && bus.exMemBubble === 1'b1) freeze++;
            tick();
            idle();
        end
        checks++; if (freeze != 4) begin
            failures++; $display("FAIL mdrst_freeze got=%0d exp=4", freeze); end
        checks++; if (bus.stallCycles !== 16'd4) begin
            failures++; $display("FAIL mdrst_cnt got=%0d exp=4", bus.stallCycles); end
    endtask

    task automatic test_saturation();
        bus_s.memReadEX     = 1'b1;
        bus_s.registerOP1EX = 4'd9;
        bus_s.registerOP1ID = 4'd9;
        for (int i = 0; i < 14; i++) tick();
        #2;
        checks++; if (bus_s.stallCycles !== 4'd14) begin
            failures++; $display("FAIL sat_14 got=%0d exp=14", bus_s.stallCycles); end
        tick();
        #2;
        checks++; if (bus_s.stallCycles !== 4'd15) begin
            failures++; $display("FAIL sat_15 got=%0d exp=15", bus_s.stallCycles); end
        for (int i = 0; i < 6; i++) tick();
        #2;
        checks++; if (bus_s.stallCycles !== 4'd15) begin
            failures++; $display("FAIL sat_hold got=%0d exp=15", bus_s.stallCycles); end
        idle_s();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle();
        idle_s();
        test_reset();
        test_load_use();
        test_muldiv();
        test_branch_priority();
        test_halt();
        test_reset_mid_muldiv();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
